// File: rtl/iomem_if.sv
// PicoSoC iomem bus bundle between the SoC master port and a memory-mapped slave.
// Handshake: master raises iomem_valid with addr/wstrb/wdata stable and holds them until it sees
// iomem_ready; slave pulses iomem_ready for exactly one cycle with iomem_rdata valid in that cycle.
interface iomem_if;
    logic        iomem_valid;
    logic        iomem_ready;
    logic [3:0]  iomem_wstrb;
    logic [31:0] iomem_addr;
    logic [31:0] iomem_wdata;
    logic [31:0] iomem_rdata;

    modport master (
        output iomem_valid, iomem_wstrb, iomem_addr, iomem_wdata,
        input  iomem_ready, iomem_rdata
    );

    modport slave (
        input  iomem_valid, iomem_wstrb, iomem_addr, iomem_wdata,
        output iomem_ready, iomem_rdata
    );
endinterface

// File: rtl/iomem_led_pwm.sv
// Eight-channel PWM LED driver on the iomem bus: per-LED duty, enable mask and shared prescaler.
// Duty changes are shadowed to period boundaries so dimming never glitches mid-period.
module iomem_led_pwm #(
    parameter logic [31:0] BASE_ADDR  = 32'h0300_0000,
    parameter int          PRESCALE_W = 16
) (
    input  logic        clk,
    input  logic        reset,
    iomem_if.slave      bus,
    output logic [7:0]  leds
);

    logic [7:0]            en;
    logic [7:0]            en_nxt;
    logic [7:0][7:0]       duty;
    logic [7:0][7:0]       duty_nxt;
    logic [7:0][7:0]       active_duty;
    logic [PRESCALE_W-1:0] presc;
    logic [PRESCALE_W-1:0] presc_nxt;
    logic [PRESCALE_W-1:0] pre_cnt;
    logic [7:0]            pwm_cnt;
    logic [31:0]           rd_mux;

    logic       sel;
    logic       wr;
    logic [5:0] word;
    logic       wr_ctrl;
    logic       wr_duta;
    logic       wr_dutb;
    logic       wr_presc;
    logic       tick;
    logic       wrap;
    logic       unused_bits;

    // The !ready term turns a held valid into one ack every other cycle.
    assign sel      = bus.iomem_valid && (bus.iomem_addr[31:8] == BASE_ADDR[31:8]) && !bus.iomem_ready;
    assign wr       = sel && (bus.iomem_wstrb != 4'b0000);
    assign word     = bus.iomem_addr[7:2];
    assign wr_ctrl  = wr && (word == 6'd0);
    assign wr_duta  = wr && (word == 6'd1);
    assign wr_dutb  = wr && (word == 6'd2);
    assign wr_presc = wr && (word == 6'd3);
    assign tick     = (pre_cnt == presc);
    assign wrap     = tick && (pwm_cnt == 8'hFF);
    assign unused_bits = &{1'b0, bus.iomem_addr[1:0]};

    always_comb begin
        en_nxt    = en;
        duty_nxt  = duty;
        presc_nxt = presc;
        if (wr_ctrl && bus.iomem_wstrb[0]) begin
            en_nxt = bus.iomem_wdata[7:0];
        end
        for (int b = 0; b < 4; b++) begin
            if (wr_duta && bus.iomem_wstrb[b]) duty_nxt[b]     = bus.iomem_wdata[8*b +: 8];
            if (wr_dutb && bus.iomem_wstrb[b]) duty_nxt[b + 4] = bus.iomem_wdata[8*b +: 8];
        end
        for (int k = 0; k < PRESCALE_W; k++) begin
            if (wr_presc && bus.iomem_wstrb[k >> 3]) presc_nxt[k] = bus.iomem_wdata[k];
        end
    end

    always_comb begin
        rd_mux = '0;
        case (word)
            6'd0:    rd_mux = {24'd0, en};
            6'd1:    rd_mux = duty[3:0];
            6'd2:    rd_mux = duty[7:4];
            6'd3:    rd_mux = 32'(presc);
            default: rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bus.iomem_ready <= 1'b0;
            bus.iomem_rdata <= '0;
            en              <= '0;
            duty            <= '0;
            active_duty     <= '0;
            presc           <= '0;
            pre_cnt         <= '0;
            pwm_cnt         <= '0;
            leds            <= '0;
        end else begin
            bus.iomem_ready <= sel;
            bus.iomem_rdata <= sel ? rd_mux : 32'd0;
            en              <= en_nxt;
            duty            <= duty_nxt;
            presc           <= presc_nxt;

            if (wr_presc) begin
                pre_cnt <= '0;
                pwm_cnt <= '0;
            end else if (tick) begin
                pre_cnt <= '0;
                pwm_cnt <= pwm_cnt + 8'd1;
            end else begin
                pre_cnt <= pre_cnt + 1'b1;
            end

            // Shadow load uses duty_nxt so a write landing on the wrap edge takes effect at once.
            for (int i = 0; i < 8; i++) begin
                if (wr_presc || wrap || !en[i]) begin
                    active_duty[i] <= duty_nxt[i];
                end
                leds[i] <= en[i] && ((active_duty[i] == 8'hFF) || (pwm_cnt < active_duty[i]));
            end
        end
    end

endmodule
